// File: rtl/t07_spi_target.sv
// t07_spi_target: SPI mode-0 target for the 16-bit {command, data} TFT link, oversampled by clk.
// Optional feature: define T07_SPI_TARGET_STATUS_EN to enable the cmd 11 status read.
module t07_spi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              rd_req,
  input  logic [7:0]        reg_rdata,
  output logic              frame_done,
  output logic              frame_err
);
  typedef enum logic [1:0] {DISARMED, IDLE, SHIFT, FINISH} state_t;

  localparam logic [4:0] CNT_CMD  = 5'd7;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rx_next;
  logic [7:0]  tx_q, tx_d;
  logic        rd_req_q, rd_req_d;
  logic        ld_rd_q, ld_rd_d;
  logic        miso_q, miso_d;
  logic        reg_we_q, reg_we_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
`ifdef T07_SPI_TARGET_STATUS_EN
  logic        st_req_q, st_req_d;
  logic        ld_st_q, ld_st_d;
  logic        err_sticky_q, err_sticky_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
`endif

  logic cs_s, sclk_s, mosi_s;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rx_next   = {rx_q[14:0], mosi_s};

  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_prev_d    = cs_s;
    sclk_prev_d  = sclk_s;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    rd_req_d     = 1'b0;
    ld_rd_d      = rd_req_q;
    reg_we_d     = 1'b0;
    reg_wdata_d  = reg_wdata_q;
    reg_addr_d   = reg_addr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef T07_SPI_TARGET_STATUS_EN
    st_req_d     = 1'b0;
    ld_st_d      = st_req_q;
    err_sticky_d = err_sticky_q;
    frame_cnt_d  = frame_cnt_q;
`endif
    case (state_q)
      DISARMED: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
        end
      end
      SHIFT: begin
        // cs_n rise takes priority over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d = FINISH;
          if (cnt_q == CNT_FULL) begin
            case (rx_q[15:14])
              2'b00: begin
                reg_we_d     = 1'b1;
                reg_wdata_d  = rx_q[7:0];
                frame_done_d = 1'b1;
              end
              2'b10: begin
                reg_addr_d   = ADDR_W'(rx_q[7:0]);
                frame_done_d = 1'b1;
              end
              2'b01: frame_done_d = 1'b1;
              default: begin
`ifdef T07_SPI_TARGET_STATUS_EN
                frame_done_d = 1'b1;
                err_sticky_d = 1'b0;
`else
                frame_err_d  = 1'b1;
`endif
              end
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (ld_rd_q) tx_d = reg_rdata;
`ifdef T07_SPI_TARGET_STATUS_EN
          if (ld_st_q) tx_d = {err_sticky_q, 3'b000, frame_cnt_q};
`endif
          if (sclk_rise) begin
            rx_d = rx_next;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
            // Command byte is complete on rise 8; only bits [7:6] matter
            if (cnt_q == CNT_CMD) begin
              rd_req_d = (rx_next[7:6] == 2'b01);
`ifdef T07_SPI_TARGET_STATUS_EN
              st_req_d = (rx_next[7:6] == 2'b11);
`endif
            end
          end else if (sclk_fall && (cnt_q >= 5'd9) && (cnt_q <= 5'd15)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef T07_SPI_TARGET_STATUS_EN
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 4'd1;
    if (frame_err_d) err_sticky_d = 1'b1;
`endif
    miso_d = (state_d == SHIFT) ? tx_d[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_sync_q    <= '0;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      cs_prev_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      state_q      <= DISARMED;
      cnt_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      rd_req_q     <= 1'b0;
      ld_rd_q      <= 1'b0;
      miso_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_wdata_q  <= '0;
      reg_addr_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef T07_SPI_TARGET_STATUS_EN
      st_req_q     <= 1'b0;
      ld_st_q      <= 1'b0;
      err_sticky_q <= 1'b0;
      frame_cnt_q  <= '0;
`endif
    end else begin
      cs_sync_q    <= cs_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_prev_q    <= cs_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      rd_req_q     <= rd_req_d;
      ld_rd_q      <= ld_rd_d;
      miso_q       <= miso_d;
      reg_we_q     <= reg_we_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_addr_q   <= reg_addr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
`ifdef T07_SPI_TARGET_STATUS_EN
      st_req_q     <= st_req_d;
      ld_st_q      <= ld_st_d;
      err_sticky_q <= err_sticky_d;
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign miso       = miso_q;
  assign reg_we     = reg_we_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_addr   = reg_addr_q;
  assign rd_req     = rd_req_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
